neuron_seq_mac: RTL

//  Parametrised, sequential successor of the fixed 784-input neuron. Streams LANES
//  (activation, weight) pairs per beat into a MAC. Adds bias, applies a piecewise-linear

---
 rtl/neuron_seq_mac_if.sv | 28 ++
 rtl/neuron_seq_mac.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/neuron_seq_mac_if.sv
// Handshake bundle for neuron_seq_mac: start/bias request, streamed
// activation/weight beats, and the activation/derivative result.
interface neuron_seq_mac_if #(
   parameter int LANES  = 1,
   parameter int DATA_W = 32
) ();
   logic                      start_valid;
   logic                      start_ready;
   logic [DATA_W-1:0]         bias;
   logic                      in_valid;
   logic                      in_ready;
   logic [LANES*DATA_W-1:0]   in_act;
   logic [LANES*DATA_W-1:0]   in_weight;
   logic                      out_valid;
   logic                      out_ready;
   logic [DATA_W-1:0]         activ;
   logic [DATA_W-1:0]         sigma_prime;

   modport master (
      output start_valid, bias, in_valid, in_act, in_weight, out_ready,
      input  start_ready, in_ready, out_valid, activ, sigma_prime
   );

   modport slave (
      input  start_valid, bias, in_valid, in_act, in_weight, out_ready,
      output start_ready, in_ready, out_valid, activ, sigma_prime
   );
endinterface

// File: rtl/neuron_seq_mac.sv
// Sequential neuron: streams LANES activation/weight pairs per beat into a MAC,
// adds bias, applies a piecewise-linear sigmoid and derives a*(1-a).
module neuron_seq_mac #(
   parameter int N_INPUTS = 784,
   parameter int LANES    = 1,
   parameter int DATA_W   = 32,
   parameter int FRAC_W   = 24
) (
   input logic             clk,
   input logic             rst_n,
   neuron_seq_mac_if.slave bus
);
   localparam int BEATS = N_INPUTS / LANES;
   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int ACC_W = 2 * DATA_W + $clog2(N_INPUTS);
   localparam int P_W   = 2 * DATA_W;

   localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);
   localparam logic [DATA_W-1:0] ONE   = DATA_W'(1)  << FRAC_W;
   localparam logic [DATA_W-1:0] FIVE  = DATA_W'(5)  << FRAC_W;
   localparam logic [DATA_W-1:0] T_HI  = DATA_W'(19) << (FRAC_W - 3);
   localparam logic [DATA_W-1:0] C_HI  = DATA_W'(27) << (FRAC_W - 5);
   localparam logic [DATA_W-1:0] C_MID = DATA_W'(5)  << (FRAC_W - 3);
   localparam logic [DATA_W-1:0] C_LO  = DATA_W'(1)  << (FRAC_W - 1);
   localparam logic [DATA_W-1:0] Z_NEG_FULL = {1'b1, {(DATA_W-1){1'b0}}};
   localparam logic signed [ACC_W-1:0] Z_MAX = ACC_W'({1'b0, {(DATA_W-1){1'b1}}});
   localparam logic signed [ACC_W-1:0] Z_MIN = ~Z_MAX;

   typedef enum logic [2:0] {
      S_IDLE, S_ACCUM, S_FINAL, S_ACT, S_DERIV, S_OUT
   } state_t;

   state_t                    state;
   logic [CNT_W-1:0]          cnt;
   logic signed [ACC_W-1:0]   acc;
   logic signed [DATA_W-1:0]  bias_r;
   logic [DATA_W-1:0]         z;
   logic [DATA_W-1:0]         a_r;

   logic signed [ACC_W-1:0]   beat_sum;
   logic signed [P_W-1:0]     act_x;
   logic signed [P_W-1:0]     wt_x;
   logic signed [ACC_W-1:0]   z_wide;
   logic signed [ACC_W-1:0]   z_sat;
   logic                      z_neg;
   logic [DATA_W-1:0]         abs_z;
   logic [DATA_W-1:0]         y;
   logic [DATA_W-1:0]         a_next;
   logic [DATA_W-1:0]         one_m;
   logic [P_W-1:0]            sp_prod;
   logic [DATA_W-1:0]         sp_next;

   // Sum of the signed lane products of the current beat
   always_comb begin
      beat_sum = '0;
      act_x    = '0;
      wt_x     = '0;
      for (int unsigned i = 0; i < LANES; i++) begin
         act_x    = P_W'($signed(bus.in_act[i*DATA_W +: DATA_W]));
         wt_x     = P_W'($signed(bus.in_weight[i*DATA_W +: DATA_W]));
         beat_sum = beat_sum + ACC_W'(act_x * wt_x);
      end
   end

   // Rescale accumulator, add bias and clamp to the DATA_W signed range
   always_comb begin
      z_wide = (acc >>> FRAC_W) + ACC_W'(bias_r);
      if (z_wide > Z_MAX)      z_sat = Z_MAX;
      else if (z_wide < Z_MIN) z_sat = Z_MIN;
      else                     z_sat = z_wide;
   end

   // Piecewise-linear sigmoid evaluated on |z|, mirrored for negative z
   always_comb begin
      z_neg = z[DATA_W-1];
      abs_z = z_neg ? (~z + 1'b1) : z;
      // the most negative z has no positive magnitude; force the top segment
      if ((z == Z_NEG_FULL) || (abs_z >= FIVE)) y = ONE;
      else if (abs_z >= T_HI)                   y = (abs_z >> 5) + C_HI;
      else if (abs_z >= ONE)                    y = (abs_z >> 3) + C_MID;
      else                                      y = (abs_z >> 2) + C_LO;
      a_next = z_neg ? (ONE - y) : y;
   end

   // Sigmoid derivative a*(1-a), a is always within [0, 1.0]
   always_comb begin
      one_m   = ONE - a_r;
      sp_prod = P_W'(a_r) * P_W'(one_m);
      sp_next = DATA_W'(sp_prod >> FRAC_W);
   end

   // Control FSM with registered handshake flags and result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= S_IDLE;
         cnt             <= '0;
         acc             <= '0;
         bias_r          <= '0;
         z               <= '0;
         a_r             <= '0;
         bus.start_ready <= 1'b1;
         bus.in_ready    <= 1'b0;
         bus.out_valid   <= 1'b0;
         bus.activ       <= '0;
         bus.sigma_prime <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.start_valid) begin
                  bias_r          <= $signed(bus.bias);
                  acc             <= '0;
                  cnt             <= '0;
                  bus.start_ready <= 1'b0;
                  bus.in_ready    <= 1'b1;
                  state           <= S_ACCUM;
               end
            end
            S_ACCUM: begin
               if (bus.in_valid) begin
                  acc <= acc + beat_sum;
                  if (cnt == LAST_BEAT) begin
                     bus.in_ready <= 1'b0;
                     state        <= S_FINAL;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            S_FINAL: begin
               z     <= DATA_W'(z_sat);
               state <= S_ACT;
            end
            S_ACT: begin
               a_r   <= a_next;
               state <= S_DERIV;
            end
            S_DERIV: begin
               bus.activ       <= a_r;
               bus.sigma_prime <= sp_next;
               bus.out_valid   <= 1'b1;
               state           <= S_OUT;
            end
            S_OUT: begin
               if (bus.out_ready) begin
                  bus.out_valid   <= 1'b0;
                  bus.start_ready <= 1'b1;
                  state           <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule
